// File: rtl/music_sequencer.sv
// music_sequencer: score player for one music channel.
// Walks a synchronous song ROM of {note[31:24], duration[23:0]} words,
// holds play_enable high for each note's duration, inserts GAP_CYCLES of
// silence between notes, and stops or loops at an end marker (note 8'hFF).
// Optional feature macro: MUSIC_SEQ_TEMPO_EN adds tempo_shift[1:0], which
// divides every note duration by 2^tempo_shift (minimum 1 cycle).
module music_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int GAP_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
`ifdef MUSIC_SEQ_TEMPO_EN
  input  logic [1:0]        tempo_shift,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [7:0]        note,
  output logic [23:0]       duration,
  output logic              play_enable,
  output logic              busy,
  output logic              done
);

  // One counter serves both the note duration and the gap, so it must hold
  // whichever is larger.
  localparam int GAP_BITS = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W    = (GAP_BITS > 24) ? GAP_BITS : 24;
  localparam bit HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        note_q, note_d;
  logic [23:0]       dur_q, dur_d;
  logic              play_q, play_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [7:0]        rom_note;
  logic [23:0]       rom_dur;
  logic [23:0]       eff_dur;

  assign rom_note = rom_data[31:24];
  assign rom_dur  = rom_data[23:0];

`ifdef MUSIC_SEQ_TEMPO_EN
  logic [23:0] shifted_dur;
  // Tempo scaling: shift the ROM duration down, never below one cycle.
  always_comb begin
    shifted_dur = rom_dur >> tempo_shift;
    eff_dur     = (shifted_dur == 24'd0) ? 24'd1 : shifted_dur;
  end
`else
  assign eff_dur = rom_dur;
`endif

  // Next-state and output logic; stop overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    dur_d   = dur_q;
    play_d  = play_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start && !stop) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Address was presented this cycle; ROM word is valid next cycle.
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (rom_note == 8'hFF) begin
          addr_d = '0;
          if (loop_en) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else if (rom_dur == 24'd0) begin
          // Zero-length words are skipped without touching the outputs.
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else begin
          note_d  = rom_note;
          dur_d   = eff_dur;
          play_d  = 1'b1;
          cnt_d   = CNT_W'(eff_dur) - CNT_W'(1);
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (cnt_q == '0) begin
          play_d = 1'b0;
          if (HAS_GAP) begin
            cnt_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = '0;
      note_d  = 8'd0;
      dur_d   = 24'd0;
      play_d  = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      note_q  <= 8'd0;
      dur_q   <= 24'd0;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr    = addr_q;
  assign note        = note_q;
  assign duration    = dur_q;
  assign play_enable = play_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: directed checks of music_sequencer with GAP_CYCLES=4
// against a behavioural synchronous song ROM.
module tb_music_sequencer;

  localparam int ADDR_W = 8;
  localparam int GAP    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data = 32'd0;
  logic [7:0]        note;
  logic [23:0]       duration;
  logic              play_enable;
  logic              busy;
  logic              done;
`ifdef MUSIC_SEQ_TEMPO_EN
  logic [1:0]        tempo_shift = 2'd0;
`endif

  logic [31:0] rom [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  music_sequencer #(.ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
`ifdef MUSIC_SEQ_TEMPO_EN
    .tempo_shift (tempo_shift),
`endif
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note        (note),
    .duration    (duration),
    .play_enable (play_enable),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Count done pulses as seen away from the active edge.
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 32'hFF00_0000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count consecutive low samples of play_enable (returns on first high).
  task automatic measure_low(output int n);
    n = 0;
    while (play_enable === 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Count consecutive high samples of play_enable (returns on first low).
  task automatic measure_high(output int n);
    n = 0;
    while (play_enable === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Cycles from now until done is seen (capped at 30).
  task automatic wait_done(output int idx);
    idx = 30;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        idx = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_play"}, {31'd0, play_enable}, 32'd0);
    check({tag, "_note"}, {24'd0, note}, 32'd0);
    check({tag, "_dur"},  {8'd0, duration}, 32'd0);
    check({tag, "_addr"}, {24'd0, rom_addr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    rst_n   = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    clear_rom();

    // Reset values.
    #3 rst_n = 1'b0;
    #1 check_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two notes, gap, end marker without loop.
    rom[0] = {8'h08, 24'd10};
    rom[1] = {8'h0C, 24'd20};
    rom[2] = {8'hFF, 24'd0};
    d0 = done_cnt;
    pulse_start();
    check("t1_busy", {31'd0, busy}, 32'd1);
    measure_low(n);
    check("t1_latency", n, 2);
    check("t1_note0", {24'd0, note}, 32'h08);
    check("t1_dur0", {8'd0, duration}, 32'd10);
    measure_high(n);
    check("t1_high0", n, 10);
    measure_low(n);
    check("t1_gap", n, 6);
    check("t1_note1", {24'd0, note}, 32'h0C);
    check("t1_dur1", {8'd0, duration}, 32'd20);
    measure_high(n);
    check("t1_high1", n, 20);
    wait_done(n);
    check("t1_done_at", n, 6);
    check("t1_busy_fall", {31'd0, busy}, 32'd0);
    check("t1_addr_end", {24'd0, rom_addr}, 32'd0);
    repeat (3) @(negedge clk);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_done_low", {31'd0, done}, 32'd0);

    // Same score, looping; then start+stop together mid-PLAY.
    loop_en = 1'b1;
    d0 = done_cnt;
    pulse_start();
    measure_low(n);
    check("t2_latency", n, 2);
    measure_high(n);
    check("t2_high0", n, 10);
    measure_low(n);
    check("t2_gap", n, 6);
    measure_high(n);
    check("t2_high1", n, 20);
    measure_low(n);
    check("t2_loop_gap", n, 8);
    check("t2_note_pass2", {24'd0, note}, 32'h08);
    measure_high(n);
    check("t2_high2", n, 10);
    measure_low(n);
    check("t2_gap2", n, 6);
    check("t2_note3", {24'd0, note}, 32'h0C);
    repeat (5) @(negedge clk);
    check("t2_midplay", {31'd0, play_enable}, 32'd1);
    stop  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    check_idle("t2_stop");
    @(negedge clk);
    check("t2_start_ignored", {31'd0, busy}, 32'd0);
    check("t2_no_done", done_cnt - d0, 0);
    loop_en = 1'b0;

    // Long note: start while busy ignored, stop mid-PLAY, replay from 0.
    clear_rom();
    rom[0] = {8'h21, 24'd1000};
    d0 = done_cnt;
    pulse_start();
    measure_low(n);
    check("t3_latency", n, 2);
    repeat (300) @(negedge clk);
    check("t3_playing", {31'd0, play_enable}, 32'd1);
    pulse_start();
    check("t3_busy_start_play", {31'd0, play_enable}, 32'd1);
    check("t3_busy_start_note", {24'd0, note}, 32'h21);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle("t3_stop");
    repeat (3) @(negedge clk);
    check("t3_no_done", done_cnt - d0, 0);
    pulse_start();
    measure_low(n);
    check("t3_replay_latency", n, 2);
    check("t3_replay_note", {24'd0, note}, 32'h21);
    check("t3_replay_addr", {24'd0, rom_addr}, 32'd0);
    check("t3_replay_dur", {8'd0, duration}, 32'd1000);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t3_stop2_busy", {31'd0, busy}, 32'd0);

    // Zero-duration word is skipped.
    clear_rom();
    rom[0] = {8'h05, 24'd0};
    rom[1] = {8'h06, 24'd3};
    d0 = done_cnt;
    pulse_start();
    measure_low(n);
    check("t4_latency", n, 4);
    check("t4_note", {24'd0, note}, 32'h06);
    check("t4_dur", {8'd0, duration}, 32'd3);
    measure_high(n);
    check("t4_high", n, 3);
    wait_done(n);
    check("t4_done_at", n, 6);
    repeat (2) @(negedge clk);
    check("t4_done_once", done_cnt - d0, 1);

    // Asynchronous reset in the middle of a gap.
    clear_rom();
    rom[0] = {8'h08, 24'd10};
    rom[1] = {8'h0C, 24'd20};
    pulse_start();
    measure_low(n);
    measure_high(n);
    check("t5_high", n, 10);
    @(negedge clk);
    check("t5_in_gap_busy", {31'd0, busy}, 32'd1);
    check("t5_in_gap_note", {24'd0, note}, 32'h08);
    #2 rst_n = 1'b0;
    #1 check_idle("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef MUSIC_SEQ_TEMPO_EN
    // Tempo scaling with clamping to one cycle.
    clear_rom();
    rom[0] = {8'h10, 24'd16};
    rom[1] = {8'h11, 24'd2};
    tempo_shift = 2'd2;
    pulse_start();
    measure_low(n);
    check("t6_latency", n, 2);
    check("t6_dur0", {8'd0, duration}, 32'd4);
    measure_high(n);
    check("t6_high0", n, 4);
    measure_low(n);
    check("t6_gap", n, 6);
    check("t6_dur1", {8'd0, duration}, 32'd1);
    measure_high(n);
    check("t6_high1", n, 1);
    wait_done(n);
    check("t6_done_at", n, 6);
    tempo_shift = 2'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
